// File: rtl/regfile_alu_pipe.sv
// Two-stage register file + ALU: stage D decodes and reads operands (with forwarding),
// stage E executes ADD/SUB/AND/OR, writes back and registers the result and Z/N/C/V flags.
module regfile_alu_pipe #(
   parameter int DATA_W = 32,
   parameter int AW     = 4,
   localparam int IW    = 2 + 3 * AW
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [IW-1:0]     instruction,
   input  logic              write_en,
   input  logic              ld_en,
   input  logic [AW-1:0]     ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              Z,
   output logic              N,
   output logic              C,
   output logic              V
);

   localparam int NREGS = 2 ** AW;

   logic [DATA_W-1:0] regs [NREGS];

   logic [1:0]        op;
   logic [AW-1:0]     waddr, raddr1, raddr2;

   logic              de_valid;
   logic [1:0]        de_op;
   logic [AW-1:0]     de_waddr;
   logic              de_we;
   logic [DATA_W-1:0] de_a, de_b;

   logic [DATA_W-1:0] alu_r;
   logic              alu_c, alu_v;
   logic [DATA_W:0]   sum, diff;
   logic              wb, fwd1, fwd2;

   assign op     = instruction[IW-1 -: 2];
   assign waddr  = instruction[3*AW-1 -: AW];
   assign raddr1 = instruction[2*AW-1 -: AW];
   assign raddr2 = instruction[AW-1:0];

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      sum   = {1'b0, de_a} + {1'b0, de_b};
      diff  = {1'b0, de_a} - {1'b0, de_b};
      unique case (de_op)
         2'b00: begin
            alu_r = sum[DATA_W-1:0];
            alu_c = sum[DATA_W];
            alu_v = (de_a[DATA_W-1] == de_b[DATA_W-1]) && (alu_r[DATA_W-1] != de_a[DATA_W-1]);
         end
         2'b01: begin
            alu_r = diff[DATA_W-1:0];
            // Borrow out of the extended subtract; C means "no borrow".
            alu_c = ~diff[DATA_W];
            alu_v = (de_a[DATA_W-1] != de_b[DATA_W-1]) && (alu_r[DATA_W-1] != de_a[DATA_W-1]);
         end
         2'b10: alu_r = de_a & de_b;
         2'b11: alu_r = de_a | de_b;
      endcase
   end

   assign wb   = de_valid && de_we;
   assign fwd1 = wb && (de_waddr == raddr1);
   assign fwd2 = wb && (de_waddr == raddr2);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         de_valid     <= 1'b0;
         de_op        <= '0;
         de_waddr     <= '0;
         de_we        <= 1'b0;
         de_a         <= '0;
         de_b         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         Z            <= 1'b0;
         N            <= 1'b0;
         C            <= 1'b0;
         V            <= 1'b0;
      end else begin
         de_valid <= instr_valid;
         if (instr_valid) begin
            de_op    <= op;
            de_waddr <= waddr;
            de_we    <= write_en;
            de_a     <= fwd1 ? alu_r : regs[raddr1];
            de_b     <= fwd2 ? alu_r : regs[raddr2];
         end
         result_valid <= de_valid;
         if (de_valid) begin
            result <= alu_r;
            Z      <= (alu_r == '0);
            N      <= alu_r[DATA_W-1];
            C      <= alu_c;
            V      <= alu_v;
         end
         // Writeback has priority over a host preload to the same register.
         for (int i = 0; i < NREGS; i++) begin
            if (wb && (de_waddr == AW'(i))) regs[i] <= alu_r;
            else if (ld_en && (ld_addr == AW'(i))) regs[i] <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe: an architectural model predicts each result at issue
// time, pushes it to a scoreboard, and a negedge monitor pops and checks every result pulse.
module tb_regfile_alu_pipe;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, OR_ = 2'b11;

   typedef struct {
      logic [DW-1:0] r;
      logic [3:0]    f;  // {Z,N,C,V}
   } exp_t;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            instr_valid = 1'b0;
   logic [2+3*AW-1:0] instruction = '0;
   logic            write_en = 1'b0;
   logic            ld_en = 1'b0;
   logic [AW-1:0]   ld_addr = '0;
   logic [DW-1:0]   ld_data = '0;
   logic [DW-1:0]   result;
   logic            result_valid, Z, N, C, V;

   int errors = 0;
   int checks = 0;
   exp_t sb[$];
   logic [DW-1:0] mregs [16];

   regfile_alu_pipe #(.DATA_W(DW), .AW(AW)) dut (
      .clock(clock), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
      .write_en(write_en), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .result(result), .result_valid(result_valid), .Z(Z), .N(N), .C(C), .V(V)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
      exp_t e;
      longint unsigned ua, ub, u;
      longint sa, sb2, s;
      logic c, v;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = $signed(a);
      sb2 = $signed(b);
      c = 1'b0;
      v = 1'b0;
      case (o)
         ADD: begin
            u = ua + ub; e.r = u[31:0]; c = u[32];
            s = sa + sb2; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         SUB: begin
            u = ua - ub; e.r = u[31:0]; c = (a >= b);
            s = sa - sb2; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         AND_: e.r = a & b;
         default: e.r = a | b;
      endcase
      e.f = {(e.r == 0), e.r[31], c, v};
      return e;
   endfunction

   always @(negedge clock) begin
      if (result_valid === 1'b1) begin
         exp_t e;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_result_valid: got result=%h, required no pulse", result);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (result === e.r) else begin
               errors++;
               $error("FAIL result: got %h, required %h", result, e.r);
            end
            checks++;
            assert ({Z, N, C, V} === e.f) else begin
               errors++;
               $error("FAIL flags ZNCV: got %b, required %b (result %h)", {Z, N, C, V}, e.f, e.r);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] o, input int w, input int r1, input int r2,
                        input logic we, input bit track);
      exp_t e;
      instr_valid = 1'b1;
      instruction = {o, 4'(w), 4'(r1), 4'(r2)};
      write_en = we;
      if (track) begin
         e = model(o, mregs[r1], mregs[r2]);
         sb.push_back(e);
         if (we) mregs[w] = e.r;
      end
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic preload(input int a, input logic [DW-1:0] d);
      ld_en = 1'b1;
      ld_addr = 4'(a);
      ld_data = d;
      @(posedge clock);
      #1;
      ld_en = 1'b0;
      mregs[a] = d;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(negedge clock);
         #1;
      end
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL %s_drain: %0d results still pending, required 0", tag, sb.size());
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      assert ({result, result_valid, Z, N, C, V} === {32'h0, 5'b0}) else begin
         errors++;
         $error("FAIL %s: got result=%h rv=%b ZNCV=%b, required all 0", tag, result,
                result_valid, {Z, N, C, V});
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      repeat (2) @(posedge clock);
      #1;
      check_idle_outputs("reset_outputs");
      reset = 1'b0;

      // Basic ADD and register readback via OR Rx|Rx without writeback.
      preload(1, 32'd5);
      preload(2, 32'd3);
      issue(ADD, 0, 1, 2, 1'b1, 1'b1);
      issue(OR_, 9, 0, 0, 1'b0, 1'b1);
      drain("basic");

      // Back-to-back with forwarding on both operand positions.
      issue(ADD, 0, 1, 2, 1'b1, 1'b1);
      issue(SUB, 4, 0, 1, 1'b1, 1'b1);
      issue(AND_, 5, 4, 2, 1'b1, 1'b1);
      issue(ADD, 6, 5, 5, 1'b1, 1'b1);
      issue(OR_, 8, 6, 6, 1'b0, 1'b1);
      drain("forward");

      // Signed overflow and carry out.
      preload(1, 32'h7FFF_FFFF);
      preload(2, 32'h0000_0001);
      issue(ADD, 3, 1, 2, 1'b1, 1'b1);
      preload(1, 32'hFFFF_FFFF);
      issue(ADD, 3, 1, 2, 1'b1, 1'b1);
      preload(1, 32'h8000_0000);
      issue(SUB, 10, 1, 2, 1'b1, 1'b1);
      drain("overflow");

      // Subtraction borrow and zero.
      preload(1, 32'd2);
      preload(2, 32'd3);
      issue(SUB, 3, 1, 2, 1'b1, 1'b1);
      issue(SUB, 3, 1, 1, 1'b1, 1'b1);
      drain("sub");

      // write_en=0 leaves the target untouched.
      issue(ADD, 7, 1, 2, 1'b0, 1'b1);
      issue(OR_, 11, 7, 7, 1'b0, 1'b1);
      drain("nowrite");

      // Writeback beats a same-edge preload of the same register.
      issue(ADD, 0, 1, 2, 1'b1, 1'b1);
      ld_en = 1'b1;
      ld_addr = 4'd0;
      ld_data = 32'hDEAD_BEEF;
      @(posedge clock);
      #1;
      ld_en = 1'b0;
      issue(OR_, 12, 0, 0, 1'b0, 1'b1);
      drain("ld_conflict");

      // A same-edge preload is not forwarded into stage D.
      preload(3, 32'h0000_0011);
      ld_en = 1'b1;
      ld_addr = 4'd3;
      ld_data = 32'h0000_0022;
      issue(OR_, 6, 3, 3, 1'b0, 1'b1);
      ld_en = 1'b0;
      mregs[3] = 32'h0000_0022;
      issue(OR_, 6, 3, 3, 1'b1, 1'b1);
      drain("ld_noforward");

      // Reset with an instruction in flight: no pulse, no writeback, everything zeroed.
      issue(ADD, 13, 1, 2, 1'b1, 1'b0);
      reset = 1'b1;
      #2;
      check_idle_outputs("midreset_outputs");
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      @(negedge clock);
      check_idle_outputs("post_reset_outputs");
      for (int i = 0; i < 16; i++) issue(OR_, 0, i, i, 1'b0, 1'b1);
      drain("post_reset_regs");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
